calc_input_fsm: RTL

CALC_INPUT_FSM -- requirements
Module: calc_input_fsm

---
 rtl/calc_input_fsm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/calc_input_fsm.sv
// calc_input_fsm
// Operand-entry state machine for a switch-driven calculator. Operand A,
// operand B and an operation code are captured from the switches on
// successive presses of the enter button. The result is computed on the
// same clock edge as the operation-code capture and is held for display
// until the next press.
//
// Ports
//   clk          sole clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   sw           operand value from the switches (synchronous to clk)
//   op_sw        operation code from the switches (synchronous to clk)
//   enter        debounced enter-button level (synchronous to clk)
//   state        current state code, drives the display-select mux
//   op_a         latched operand A
//   op_b         latched operand B
//   op_code      latched operation code
//   result       registered ALU result
//   carry        carry (add) or borrow (sub) of the last operation
//   result_valid high while the machine is showing a result

module calc_input_fsm #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic [OP_W-1:0]   op_sw,
    input  logic              enter,
    output logic [2:0]        state,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OP_W-1:0]   op_code,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              result_valid
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        LOAD_A  = 3'd1,
        WAIT_B  = 3'd2,
        LOAD_B  = 3'd3,
        WAIT_OP = 3'd4,
        SHOW    = 3'd5
    } state_t;

    state_t            state_q;
    logic              enter_q;
    logic [DATA_W-1:0] opA_q;
    logic [DATA_W-1:0] opB_q;
    logic [OP_W-1:0]   opCode_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              resultValid_q;

    logic              enterRise;
    logic [DATA_W:0]   addFull;
    logic [DATA_W:0]   subFull;
    logic [DATA_W-1:0] aluResult_d;
    logic              aluCarry_d;

    // One-cycle pulse per press. enter_q resets high so a button held
    // through reset release does not look like a fresh press.
    assign enterRise = enter & ~enter_q;

    // The extra top bit of the add is the carry-out; for the subtract it
    // becomes 1 exactly when A < B unsigned, which is the borrow.
    assign addFull = {1'b0, opA_q} + {1'b0, opB_q};
    assign subFull = {1'b0, opA_q} - {1'b0, opB_q};

    // ALU works from the latched operands and the live op switches, so its
    // output is ready to be registered on the edge that captures op_code.
    // Only the low three op bits select the operation.
    always_comb begin
        aluResult_d = '0;
        aluCarry_d  = 1'b0;
        case (op_sw[2:0])
            3'b000: begin
                aluResult_d = addFull[DATA_W-1:0];
                aluCarry_d  = addFull[DATA_W];
            end
            3'b001: begin
                aluResult_d = subFull[DATA_W-1:0];
                aluCarry_d  = subFull[DATA_W];
            end
            3'b010:  aluResult_d = opA_q & opB_q;
            3'b011:  aluResult_d = opA_q | opB_q;
            3'b100:  aluResult_d = opA_q ^ opB_q;
            default: aluResult_d = '0;
        endcase
    end

    // Main sequencer. Every output is a register updated here, so the
    // display sees clean values. The LOAD states ignore enter entirely,
    // and any unreachable code falls back to WAIT_A with data cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_A;
            enter_q       <= 1'b1;
            opA_q         <= '0;
            opB_q         <= '0;
            opCode_q      <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            resultValid_q <= 1'b0;
        end else begin
            enter_q <= enter;
            case (state_q)
                WAIT_A: begin
                    if (enterRise) begin
                        opA_q   <= sw;
                        state_q <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    state_q <= WAIT_B;
                end
                WAIT_B: begin
                    if (enterRise) begin
                        opB_q   <= sw;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    state_q <= WAIT_OP;
                end
                WAIT_OP: begin
                    if (enterRise) begin
                        opCode_q      <= op_sw;
                        result_q      <= aluResult_d;
                        carry_q       <= aluCarry_d;
                        resultValid_q <= 1'b1;
                        state_q       <= SHOW;
                    end
                end
                SHOW: begin
                    if (enterRise) begin
                        opA_q         <= '0;
                        opB_q         <= '0;
                        opCode_q      <= '0;
                        result_q      <= '0;
                        carry_q       <= 1'b0;
                        resultValid_q <= 1'b0;
                        state_q       <= WAIT_A;
                    end
                end
                default: begin
                    opA_q         <= '0;
                    opB_q         <= '0;
                    opCode_q      <= '0;
                    result_q      <= '0;
                    carry_q       <= 1'b0;
                    resultValid_q <= 1'b0;
                    state_q       <= WAIT_A;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign op_a         = opA_q;
    assign op_b         = opB_q;
    assign op_code      = opCode_q;
    assign result       = result_q;
    assign carry        = carry_q;
    assign result_valid = resultValid_q;

endmodule
